// File: rtl/pong_pkg.sv
// Shared types and default constants for the Speed Pong match controller.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        RALLY = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } match_state_t;

    localparam int SCORE_W            = 4;
    localparam int DEF_WIN_SCORE      = 10;
    localparam int DEF_SERVE_TICKS    = 60;
    localparam int DEF_POINT_TICKS    = 30;
    localparam int DEF_HITS_PER_LEVEL = 4;
    localparam int DEF_MAX_LEVEL      = 7;

    // The timer is at least 8 bits wide, and wider only when a delay needs it.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 255) ? $clog2(m + 1) : 8;
    endfunction

endpackage

// File: rtl/pong_tick_timer.sv
// Loadable down-counter paced by tick; done pulses on the tick that moves it 1 -> 0.
module pong_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // done must not depend on load: the controller derives load from done when leaving POINT.
    assign done = tick && (count == W'(1));

endmodule

// File: rtl/pong_match_ctrl.sv
// Speed Pong match sequencer: game state, scores, rally speed and ball run/reset controls.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = DEF_WIN_SCORE,
    parameter int SERVE_TICKS    = DEF_SERVE_TICKS,
    parameter int POINT_TICKS    = DEF_POINT_TICKS,
    parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
    parameter int MAX_LEVEL      = DEF_MAX_LEVEL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               goal_p1,
    input  logic               goal_p2,
    input  logic               paddle_hit,
    output logic               ball_reset,
    output logic               ball_run,
    output logic               serve_right,
    output logic [2:0]         speed_level,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam int TIMER_W = timer_width(SERVE_TICKS, POINT_TICKS);
    localparam int HIT_W   = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [2:0]         MAX_L     = 3'(MAX_LEVEL);
    localparam logic [HIT_W-1:0]   LAST_HIT  = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [TIMER_W-1:0] SERVE_VAL = TIMER_W'(SERVE_TICKS);
    localparam logic [TIMER_W-1:0] POINT_VAL = TIMER_W'(POINT_TICKS);

    match_state_t       cur_state, next_state;
    logic [HIT_W-1:0]   hit_cnt;
    logic               timer_load, timer_tick, timer_done;
    logic [TIMER_W-1:0] timer_value;
    logic               p1_final, p2_final;

    assign p1_final = (score1 + 4'd1) == WIN_S;
    assign p2_final = (score2 + 4'd1) == WIN_S;

    always_ff @(posedge clk) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = cur_state;
        unique case (cur_state)
            IDLE:    if (start) next_state = SERVE;
            SERVE:   if (timer_done) next_state = RALLY;
            RALLY: begin
                if (goal_p1)      next_state = p1_final ? OVER : POINT;
                else if (goal_p2) next_state = p2_final ? OVER : POINT;
            end
            POINT:   if (timer_done) next_state = SERVE;
            OVER:    if (start) next_state = SERVE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ball_run   = (cur_state == RALLY);
        ball_reset = (cur_state != RALLY);
        game_over  = (cur_state == OVER);
        state      = cur_state;
    end

    // The timer is loaded on every entry into SERVE or POINT; the load beats a same-cycle tick.
    assign timer_load  = (next_state != cur_state) && ((next_state == SERVE) || (next_state == POINT));
    assign timer_value = (next_state == SERVE) ? SERVE_VAL : POINT_VAL;
    assign timer_tick  = tick && ((cur_state == SERVE) || (cur_state == POINT));

    pong_tick_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (timer_tick),
        .done       (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            score1      <= '0;
            score2      <= '0;
            speed_level <= '0;
            hit_cnt     <= '0;
            serve_right <= 1'b0;
            winner      <= 1'b0;
        end else begin
            unique case (cur_state)
                IDLE, OVER: begin
                    if (start) begin
                        score1      <= '0;
                        score2      <= '0;
                        speed_level <= '0;
                        hit_cnt     <= '0;
                        serve_right <= 1'b0;
                        winner      <= 1'b0;
                    end
                end
                RALLY: begin
                    // Goal priority: goal_p1 over goal_p2, and any goal over a paddle hit.
                    if (goal_p1) begin
                        score1      <= score1 + 4'd1;
                        serve_right <= 1'b1;
                        if (p1_final) winner <= 1'b0;
                        speed_level <= '0;
                        hit_cnt     <= '0;
                    end else if (goal_p2) begin
                        score2      <= score2 + 4'd1;
                        serve_right <= 1'b0;
                        if (p2_final) winner <= 1'b1;
                        speed_level <= '0;
                        hit_cnt     <= '0;
                    end else if (paddle_hit) begin
                        if (hit_cnt == LAST_HIT) begin
                            hit_cnt <= '0;
                            if (speed_level != MAX_L) speed_level <= speed_level + 3'd1;
                        end else begin
                            hit_cnt <= hit_cnt + HIT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl with shortened match parameters.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick, start, goal_p1, goal_p2, paddle_hit;
    logic       ball_reset, ball_run, serve_right, game_over, winner;
    logic [2:0] speed_level, state;
    logic [3:0] score1, score2;

    int checks   = 0;
    int failures = 0;

    localparam int S_IDLE = 0, S_SERVE = 1, S_RALLY = 2, S_POINT = 3, S_OVER = 4;

    pong_match_ctrl #(
        .WIN_SCORE      (3),
        .SERVE_TICKS    (3),
        .POINT_TICKS    (2),
        .HITS_PER_LEVEL (2),
        .MAX_LEVEL      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .goal_p1     (goal_p1),
        .goal_p2     (goal_p2),
        .paddle_hit  (paddle_hit),
        .ball_reset  (ball_reset),
        .ball_run    (ball_run),
        .serve_right (serve_right),
        .speed_level (speed_level),
        .score1      (score1),
        .score2      (score2),
        .game_over   (game_over),
        .winner      (winner),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given inputs held, then all pulses dropped; outputs settle by #1.
    task automatic pulse(input logic s, input logic g1, input logic g2, input logic h, input logic t);
        start = s; goal_p1 = g1; goal_p2 = g2; paddle_hit = h; tick = t;
        @(posedge clk);
        #1;
        start = 0; goal_p1 = 0; goal_p2 = 0; paddle_hit = 0; tick = 0;
    endtask

    // Three quiet clocks then a tick clock: tick every 4th clk.
    task automatic do_tick();
        repeat (3) pulse(0, 0, 0, 0, 0);
        pulse(0, 0, 0, 0, 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    initial begin
        int exp_lvl[7] = '{0, 1, 1, 2, 2, 3, 3};

        reset = 1; tick = 0; start = 0; goal_p1 = 0; goal_p2 = 0; paddle_hit = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, S_IDLE);
        check("rst_score1", score1, 0);
        check("rst_score2", score2, 0);
        check("rst_speed", speed_level, 0);
        check("rst_serve_right", serve_right, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
        check("rst_ball_reset", ball_reset, 1);
        check("rst_ball_run", ball_run, 0);
        reset = 0;

        // 1: start, exactly 3 ticks of SERVE
        pulse(1, 0, 0, 0, 0);
        check("t1_serve", state, S_SERVE);
        check("t1_ball_reset", ball_reset, 1);
        ticks(2);
        check("t1_serve_after2", state, S_SERVE);
        do_tick();
        check("t1_rally", state, S_RALLY);
        check("t1_ball_run", ball_run, 1);
        check("t1_ball_reset_low", ball_reset, 0);

        // 2: speed ramp with saturation, then goal_p2
        for (int i = 0; i < 7; i++) begin
            pulse(0, 0, 0, 1, 0);
            check($sformatf("t2_level_hit%0d", i + 1), speed_level, exp_lvl[i]);
        end
        pulse(0, 0, 1, 0, 0);
        check("t2_score2", score2, 1);
        check("t2_serve_right", serve_right, 0);
        check("t2_speed_clr", speed_level, 0);
        check("t2_point", state, S_POINT);
        do_tick();
        check("t2_point_after1", state, S_POINT);
        do_tick();
        check("t2_serve", state, S_SERVE);
        check("t2_score2_held", score2, 1);

        // 3: simultaneous goals, goal_p1 wins
        ticks(3);
        check("t3_rally", state, S_RALLY);
        pulse(0, 1, 1, 0, 0);
        check("t3_score1", score1, 1);
        check("t3_score2", score2, 1);
        check("t3_serve_right", serve_right, 1);
        check("t3_point", state, S_POINT);

        // 6: goal coincident with a hit while hit count = 1
        ticks(5);
        check("t6_rally", state, S_RALLY);
        pulse(0, 0, 0, 1, 0);
        check("t6_level_after_hit", speed_level, 0);
        pulse(0, 1, 0, 1, 0);
        check("t6_score1", score1, 2);
        check("t6_speed", speed_level, 0);
        ticks(5);
        pulse(0, 0, 0, 1, 0);
        check("t6_hitcnt_cleared", speed_level, 0);

        // 4: third goal ends the match, OVER ignores goals and ticks
        pulse(0, 1, 0, 0, 0);
        check("t4_score1", score1, 3);
        check("t4_over", state, S_OVER);
        check("t4_game_over", game_over, 1);
        check("t4_winner", winner, 0);
        check("t4_ball_reset", ball_reset, 1);
        pulse(0, 0, 1, 0, 0);
        do_tick();
        check("t4_goal_ignored", score2, 1);
        check("t4_still_over", state, S_OVER);
        check("t4_serve_right_held", serve_right, 1);
        pulse(1, 0, 0, 0, 0);
        check("t4_restart_state", state, S_SERVE);
        check("t4_restart_s1", score1, 0);
        check("t4_restart_s2", score2, 0);
        check("t4_restart_sr", serve_right, 0);
        check("t4_restart_go", game_over, 0);

        // 5: reset mid-SERVE with score1 = 2
        ticks(3);
        pulse(0, 1, 0, 0, 0);
        ticks(5);
        pulse(0, 1, 0, 0, 0);
        ticks(3);
        check("t5_pre_serve", state, S_SERVE);
        check("t5_pre_score1", score1, 2);
        reset = 1;
        pulse(0, 0, 0, 0, 0);
        reset = 0;
        check("t5_idle", state, S_IDLE);
        check("t5_score1", score1, 0);
        check("t5_ball_reset", ball_reset, 1);
        check("t5_serve_right", serve_right, 0);
        do_tick();
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 1);
        check("t5_idle_held", state, S_IDLE);
        check("t5_s1_held", score1, 0);
        check("t5_s2_held", score2, 0);

        // Start coincident with tick: load wins, still 3 ticks of SERVE
        pulse(1, 0, 0, 0, 1);
        ticks(2);
        check("ld_tick_serve", state, S_SERVE);
        do_tick();
        check("ld_tick_rally", state, S_RALLY);

        // Player 2 wins the match
        for (int g = 1; g <= 3; g++) begin
            pulse(0, 0, 1, 0, 0);
            check($sformatf("p2_score%0d", g), score2, g);
            if (g < 3) ticks(5);
        end
        check("p2_over", state, S_OVER);
        check("p2_winner", winner, 1);
        pulse(1, 0, 0, 0, 0);
        check("p2_winner_clr", winner, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for Speed Pong.
- Owns the game state (idle, serve delay, rally, point pause, game over), both score registers, and the rally speed level.
- Drives the ball datapath's reset/run controls and serve direction from goal and paddle-hit events reported by the ball/collision logic.
- Sits between the ball/paddle datapath and the score display; paced by the paddle-rate tick.

Parameters:
- WIN_SCORE, 10: score that ends the match (1..15).
- SERVE_TICKS, 60: ticks spent in SERVE before the ball is released (>=1).
- POINT_TICKS, 30: ticks spent in POINT after a goal (>=1).
- HITS_PER_LEVEL, 4: paddle hits per speed-level increment (>=1).
- MAX_LEVEL, 7: saturation value of speed_level (<=7).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk enable at paddle rate; all timers count only on tick
- start  in  1  start/restart request, level-sampled
- goal_p1  in  1  one-clk pulse: ball passed right edge, player 1 scores
- goal_p2  in  1  one-clk pulse: ball passed left edge, player 2 scores
- paddle_hit  in  1  one-clk pulse: ball hit either paddle
- ball_reset  out  1  hold ball at centre
- ball_run  out  1  ball may move
- serve_right  out  1  next serve direction (1 = toward player 2)
- speed_level  out  3  current rally speed level
- score1  out  4  player 1 score
- score2  out  4  player 2 score
- game_over  out  1  match finished
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over
- state  out  3  current state encoding, for debug

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high, named reset.
  - Reset mid-operation returns everything to reset values on the next edge.
- Reset values:
  - state = IDLE; score1 = score2 = 0; speed_level = 0; hit count = 0; timer = 0.
  - serve_right = 0; game_over = 0; winner = 0.
- Output decode:
  - ball_reset and ball_run are Moore outputs decoded from the registered state.
  - ball_run = 1 only in RALLY; ball_reset = 1 in every other state.
  - game_over = 1 only in OVER.
- IDLE:
  - start = 1 -> SERVE.
  - On entry to SERVE: timer = SERVE_TICKS; scores, speed and hit count cleared.
- SERVE:
  - Timer decrements on each tick.
  - On the tick that takes the timer 1 -> 0, next state is RALLY.
  - Exactly SERVE_TICKS ticks are spent in SERVE.
- RALLY, goal handling:
  - goal_p1: score1 += 1, serve_right = 1.
  - goal_p2: score2 += 1, serve_right = 0.
  - If the new score == WIN_SCORE -> OVER, winner set to the scorer.
  - Otherwise -> POINT with timer = POINT_TICKS.
  - Speed_level and hit count cleared on either transition.
- RALLY, paddle hits:
  - paddle_hit (no goal that cycle) increments the hit count.
  - When the count reaches HITS_PER_LEVEL: count = 0 and speed_level += 1, saturating at MAX_LEVEL.
  - The count keeps wrapping after saturation.
- POINT:
  - Timer decrements on each tick; on 1 -> 0, -> SERVE with timer = SERVE_TICKS.
  - Scores and serve_right are held.
- OVER:
  - Scores, winner and serve_right are held.
  - start = 1 -> SERVE: scores cleared, serve_right = 0, winner = 0.
- Simultaneous events:
  - goal_p1 and goal_p2 together: goal_p1 wins, goal_p2 is ignored.
  - Goal with paddle_hit: the goal wins and the hit is ignored.
  - tick in the same cycle as a state-entry load: the load wins, no decrement.
- Ignored inputs:
  - Goals and hits outside RALLY.
  - start outside IDLE/OVER.
  - tick in IDLE, RALLY and OVER.
- Widths:
  - Scores are 4-bit and never exceed WIN_SCORE.
  - Timer is wide enough for max(SERVE_TICKS, POINT_TICKS); 8 bits at the defaults.
- Latency: an event pulse is reflected in the outputs on the next clk edge.

Decomposition:
- Package pong_pkg:
  - match_state_t enum: IDLE = 0, SERVE = 1, RALLY = 2, POINT = 3, OVER = 4.
  - Default constants for WIN_SCORE, SERVE_TICKS, POINT_TICKS, HITS_PER_LEVEL, MAX_LEVEL.
  - Score width constant (4).
- Sub-module pong_tick_timer: loadable down-counter.
  - Inputs: load, load_value, tick.
  - Output: done, a one-cycle pulse on the 1 -> 0 tick.
  - Instantiated once; shared by SERVE and POINT.

Test Plan:
Bench parameters: SERVE_TICKS = 3, POINT_TICKS = 2, WIN_SCORE = 3, HITS_PER_LEVEL = 2, MAX_LEVEL = 3; tick every 4th clk.
1. Reset, then start = 1 for 1 clk -> state SERVE, ball_reset = 1; after exactly 3 ticks -> RALLY, ball_run = 1, ball_reset = 0.
2. In RALLY, 7 paddle_hit pulses -> speed_level goes 0, 1, 1, 2, 2, 3, 3, saturating at 3. Then goal_p2 -> score2 = 1, serve_right = 0, speed_level = 0, state POINT; 2 ticks later -> SERVE.
3. goal_p1 and goal_p2 in the same cycle during RALLY -> score1 = 1, score2 unchanged, serve_right = 1.
4. Three goal_p1 rallies -> score1 = 3, game_over = 1, winner = 0. A goal_p2 pulse in OVER is ignored. start -> scores 0, state SERVE.
5. Reset asserted mid-SERVE (timer = 2) with score1 = 2 -> next edge: IDLE, all scores 0, ball_reset = 1. tick pulses and goal pulses in IDLE change nothing.
6. goal_p1 coincident with paddle_hit while hit count = 1 -> score1 += 1, speed_level stays 0, hit count cleared.
